// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (A)
// and the load/store unit (B), with registered request and per-requester responses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT_WIDTH = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  a_req_in,
    input  logic [ADDR_WIDTH-1:0] a_addr_in,
    output logic                  a_gnt_out,
    output logic                  a_done_out,
    output logic                  a_err_out,
    output logic [DATA_WIDTH-1:0] a_rdata_out,
    input  logic                  b_req_in,
    input  logic                  b_we_in,
    input  logic [ADDR_WIDTH-1:0] b_addr_in,
    input  logic [DATA_WIDTH-1:0] b_wdata_in,
    output logic                  b_gnt_out,
    output logic                  b_done_out,
    output logic                  b_err_out,
    output logic [DATA_WIDTH-1:0] b_rdata_out,
    output logic                  mem_sel_out,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_wdata_out,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in,
    input  logic                  mem_ack_in
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_A = 2'd1, BUSY_B = 2'd2} state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

    state_t                  state_q;
    logic                    last_b_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic                    a_gnt_q, a_done_q, a_err_q;
    logic                    b_gnt_q, b_done_q, b_err_q;
    logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
    logic                    sel_q, we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    grant_a_d, grant_b_d, timeout_d;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_a_d = a_req_in && (!b_req_in || last_b_q);
        grant_b_d = b_req_in && (!a_req_in || !last_b_q);
        timeout_d = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            cnt_q     <= '0;
            a_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            b_done_q  <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            a_gnt_q  <= 1'b0;
            a_done_q <= 1'b0;
            a_err_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            b_done_q <= 1'b0;
            b_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_a_d) begin
                        state_q  <= BUSY_A;
                        a_gnt_q  <= 1'b1;
                        sel_q    <= 1'b0;
                        last_b_q <= 1'b0;
                        addr_q   <= a_addr_in;
                        we_q     <= 1'b0;
                        wdata_q  <= '0;
                        cnt_q    <= '0;
                    end else if (grant_b_d) begin
                        state_q  <= BUSY_B;
                        b_gnt_q  <= 1'b1;
                        sel_q    <= 1'b1;
                        last_b_q <= 1'b1;
                        addr_q   <= b_addr_in;
                        we_q     <= b_we_in;
                        wdata_q  <= b_wdata_in;
                        cnt_q    <= '0;
                    end
                end
                BUSY_A, BUSY_B: begin
                    // An ack in the final wait cycle still completes normally.
                    if (mem_ack_in) begin
                        state_q <= IDLE;
                        if (state_q == BUSY_A) begin
                            a_rdata_q <= mem_rdata_in;
                            a_done_q  <= 1'b1;
                        end else begin
                            b_rdata_q <= mem_rdata_in;
                            b_done_q  <= 1'b1;
                        end
                    end else if (timeout_d) begin
                        state_q <= IDLE;
                        if (state_q == BUSY_A) begin
                            a_rdata_q <= '0;
                            a_done_q  <= 1'b1;
                            a_err_q   <= 1'b1;
                        end else begin
                            b_rdata_q <= '0;
                            b_done_q  <= 1'b1;
                            b_err_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_gnt_out     = a_gnt_q;
    assign a_done_out    = a_done_q;
    assign a_err_out     = a_err_q;
    assign a_rdata_out   = a_rdata_q;
    assign b_gnt_out     = b_gnt_q;
    assign b_done_out    = b_done_q;
    assign b_err_out     = b_err_q;
    assign b_rdata_out   = b_rdata_q;
    assign mem_sel_out   = sel_q;
    assign mem_req_out   = (state_q != IDLE);
    assign mem_we_out    = we_q;
    assign mem_addr_out  = addr_q;
    assign mem_wdata_out = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration order, latency and timeout.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_in = 1'b0, b_req_in = 1'b0, b_we_in = 1'b0;
    logic [AW-1:0] a_addr_in = '0, b_addr_in = '0;
    logic [DW-1:0] b_wdata_in = '0, mem_rdata_in = '0;
    logic          mem_ack_in = 1'b0;
    logic          a_gnt_out, a_done_out, a_err_out, b_gnt_out, b_done_out, b_err_out;
    logic [DW-1:0] a_rdata_out, b_rdata_out, mem_wdata_out;
    logic          mem_sel_out, mem_req_out, mem_we_out;
    logic [AW-1:0] mem_addr_out;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_WIDTH(TW), .TIMEOUT(TO)) dut (
        .clk_in(clk), .rst_in(rst),
        .a_req_in(a_req_in), .a_addr_in(a_addr_in), .a_gnt_out(a_gnt_out), .a_done_out(a_done_out),
        .a_err_out(a_err_out), .a_rdata_out(a_rdata_out),
        .b_req_in(b_req_in), .b_we_in(b_we_in), .b_addr_in(b_addr_in), .b_wdata_in(b_wdata_in),
        .b_gnt_out(b_gnt_out), .b_done_out(b_done_out), .b_err_out(b_err_out), .b_rdata_out(b_rdata_out),
        .mem_sel_out(mem_sel_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    bit exp_last_b = 1'b1;

    // Memory model: acks in BUSY cycle ack_at[who] (1-based from the grant cycle), 0 = never.
    int          ack_at[2];
    logic [31:0] rdv[2];
    bit          force_ack = 1'b0;
    int          who = 0, bcnt = 0;
    always @(negedge clk) begin
        if (rst) bcnt = 0;
        else if (a_gnt_out || b_gnt_out) begin who = b_gnt_out ? 1 : 0; bcnt = 1; end
        else if (mem_req_out) bcnt = bcnt + 1;
        else bcnt = 0;
        if ((mem_req_out && bcnt > 0 && bcnt == ack_at[who]) || force_ack) begin
            mem_ack_in = 1'b1; mem_rdata_in = rdv[who];
        end else begin
            mem_ack_in = 1'b0; mem_rdata_in = $urandom;
        end
    end

    // Observation records, index 0 = A, 1 = B.
    int          gnt_c[2], done_c[2], ngnt[2], ndone[2];
    logic        err_r[2], sel_r[2], we_r[2], rq_r[2];
    logic [31:0] rd_r[2], addr_r[2], wd_r[2];
    int          gq[$], gcq[$], dq[$], dcq[$];
    bit          hold_reqs = 1'b0;

    task automatic observe();
        if (a_gnt_out) begin
            ngnt[0]++; gnt_c[0] = cyc; sel_r[0] = mem_sel_out; addr_r[0] = mem_addr_out;
            we_r[0] = mem_we_out; wd_r[0] = mem_wdata_out; gq.push_back(0); gcq.push_back(cyc);
            if (!hold_reqs) begin a_req_in = 1'b0; a_addr_in = $urandom; end
        end
        if (b_gnt_out) begin
            ngnt[1]++; gnt_c[1] = cyc; sel_r[1] = mem_sel_out; addr_r[1] = mem_addr_out;
            we_r[1] = mem_we_out; wd_r[1] = mem_wdata_out; gq.push_back(1); gcq.push_back(cyc);
            if (!hold_reqs) begin b_req_in = 1'b0; b_addr_in = $urandom; b_wdata_in = $urandom; b_we_in = $urandom; end
        end
        if (a_done_out) begin
            ndone[0]++; done_c[0] = cyc; err_r[0] = a_err_out; rd_r[0] = a_rdata_out; rq_r[0] = mem_req_out;
            dq.push_back(0); dcq.push_back(cyc);
        end
        if (b_done_out) begin
            ndone[1]++; done_c[1] = cyc; err_r[1] = b_err_out; rd_r[1] = b_rdata_out; rq_r[1] = mem_req_out;
            dq.push_back(1); dcq.push_back(cyc);
        end
    endtask

    // Issues requests at the current negedge and records until all complete (bounded).
    task automatic run(input bit ra, input bit rb, input logic [31:0] aa, input logic [31:0] ba,
                       input logic [31:0] bw, input bit bwe, output int req_c);
        bit fin = 1'b0;
        for (int k = 0; k < 2; k++) begin ngnt[k] = 0; ndone[k] = 0; gnt_c[k] = -1; done_c[k] = -1; end
        a_req_in = ra; a_addr_in = aa;
        b_req_in = rb; b_addr_in = ba; b_wdata_in = bw; b_we_in = bwe;
        req_c = cyc;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            observe();
            if (fin) break;
            if (ndone[0] == (ra ? 1 : 0) && ndone[1] == (rb ? 1 : 0)) fin = 1'b1;
        end
        a_req_in = 1'b0; b_req_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({a_gnt_out, a_done_out, a_err_out, b_gnt_out, b_done_out, b_err_out} !== 6'b0) begin failures++; $display("FAIL reset_pulses: got %b expected 0", {a_gnt_out, a_done_out, a_err_out, b_gnt_out, b_done_out, b_err_out}); end
        checks++; if ({a_rdata_out, b_rdata_out} !== 64'b0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", {a_rdata_out, b_rdata_out}); end
        checks++; if ({mem_sel_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out} !== 67'b0) begin failures++; $display("FAIL reset_mem: got %h expected 0", {mem_sel_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out}); end
        rst = 1'b0; exp_last_b = 1'b1;
    endtask

    task automatic test_single_fetch();
        int rc;
        @(negedge clk);
        ack_at[0] = 3; rdv[0] = 32'hDEADBEEF;
        run(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, rc);
        checks++; if (gnt_c[0] !== rc + 1) begin failures++; $display("FAIL fetch_gnt_cycle: got %0d expected %0d", gnt_c[0], rc + 1); end
        checks++; if ({sel_r[0], we_r[0]} !== 2'b00) begin failures++; $display("FAIL fetch_sel_we: got %b expected 00", {sel_r[0], we_r[0]}); end
        checks++; if (addr_r[0] !== 32'h100 || wd_r[0] !== 32'h0) begin failures++; $display("FAIL fetch_addr_wdata: got %h/%h expected 100/0", addr_r[0], wd_r[0]); end
        checks++; if (done_c[0] !== rc + 4) begin failures++; $display("FAIL fetch_done_cycle: got %0d expected %0d", done_c[0], rc + 4); end
        checks++; if (rd_r[0] !== 32'hDEADBEEF || err_r[0] !== 1'b0) begin failures++; $display("FAIL fetch_rdata: got %h err %b expected deadbeef err 0", rd_r[0], err_r[0]); end
        checks++; if (ngnt[1] + ndone[1] !== 0 || b_rdata_out !== 32'h0) begin failures++; $display("FAIL fetch_b_quiet: got pulses %0d rdata %h expected 0", ngnt[1] + ndone[1], b_rdata_out); end
        exp_last_b = 1'b0;
    endtask

    task automatic test_store();
        int rc;
        @(negedge clk);
        ack_at[1] = 1; rdv[1] = 32'hCAFEF00D;
        run(1'b0, 1'b1, 32'h0, 32'h2000, 32'h12345678, 1'b1, rc);
        checks++; if ({sel_r[1], we_r[1]} !== 2'b11) begin failures++; $display("FAIL store_sel_we: got %b expected 11", {sel_r[1], we_r[1]}); end
        checks++; if (addr_r[1] !== 32'h2000 || wd_r[1] !== 32'h12345678) begin failures++; $display("FAIL store_addr_wdata: got %h/%h expected 2000/12345678", addr_r[1], wd_r[1]); end
        checks++; if (gnt_c[1] !== rc + 1 || done_c[1] !== rc + 2) begin failures++; $display("FAIL store_latency: got gnt %0d done %0d expected %0d %0d", gnt_c[1], done_c[1], rc + 1, rc + 2); end
        checks++; if (err_r[1] !== 1'b0 || ndone[0] !== 0) begin failures++; $display("FAIL store_done: got err %b a_done %0d expected 0 0", err_r[1], ndone[0]); end
        exp_last_b = 1'b1;
    endtask

    task automatic test_timeout();
        int rc;
        @(negedge clk);
        ack_at[1] = 0;
        run(1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 1'b0, rc);
        checks++; if (done_c[1] !== rc + 1 + TO) begin failures++; $display("FAIL timeout_cycle: got %0d expected %0d", done_c[1], rc + 1 + TO); end
        checks++; if (err_r[1] !== 1'b1 || rd_r[1] !== 32'h0) begin failures++; $display("FAIL timeout_err: got err %b rdata %h expected 1 0", err_r[1], rd_r[1]); end
        checks++; if (rq_r[1] !== 1'b0) begin failures++; $display("FAIL timeout_idle: got mem_req %b expected 0", rq_r[1]); end
        exp_last_b = 1'b1;
    endtask

    task automatic test_timeout_ack_edge();
        int rc;
        @(negedge clk);
        ack_at[1] = TO; rdv[1] = 32'h0BADF00D;
        run(1'b0, 1'b1, 32'h0, 32'h44, 32'h0, 1'b0, rc);
        checks++; if (done_c[1] !== rc + 1 + TO) begin failures++; $display("FAIL edge_cycle: got %0d expected %0d", done_c[1], rc + 1 + TO); end
        checks++; if (err_r[1] !== 1'b0 || rd_r[1] !== 32'h0BADF00D) begin failures++; $display("FAIL edge_ack_wins: got err %b rdata %h expected 0 0badf00d", err_r[1], rd_r[1]); end
        exp_last_b = 1'b1;
    endtask

    task automatic test_back_to_back();
        int rc, exp_id;
        @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0; exp_last_b = 1'b1;
        gq.delete(); gcq.delete(); dq.delete(); dcq.delete();
        ack_at[0] = 2; ack_at[1] = 2; rdv[0] = 32'h1; rdv[1] = 32'h2;
        hold_reqs = 1'b1;
        a_req_in = 1'b1; a_addr_in = 32'h500; b_req_in = 1'b1; b_we_in = 1'b0; b_addr_in = 32'h600;
        rc = cyc;
        for (int i = 0; i < 60 && dq.size() < 4; i++) begin @(negedge clk); observe(); end
        a_req_in = 1'b0; b_req_in = 1'b0; hold_reqs = 1'b0;
        checks++; if (dq.size() !== 4) begin failures++; $display("FAIL b2b_count: got %0d dones expected 4", dq.size()); end
        for (int k = 0; k < 4; k++) begin
            exp_id = exp_last_b ? 0 : 1;
            checks++; if (gq[k] !== exp_id || dq[k] !== exp_id) begin failures++; $display("FAIL b2b_order[%0d]: got gnt %0d done %0d expected %0d", k, gq[k], dq[k], exp_id); end
            checks++; if (gcq[k] !== rc + 1 + 3 * k || dcq[k] !== rc + 3 + 3 * k) begin failures++; $display("FAIL b2b_timing[%0d]: got %0d/%0d expected %0d/%0d", k, gcq[k], dcq[k], rc + 1 + 3 * k, rc + 3 + 3 * k); end
            exp_last_b = (exp_id == 1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midbusy();
        int nd = 0;
        bit seen = 1'b0;
        @(negedge clk);
        ack_at[0] = 0; ack_at[1] = 0; rdv[0] = 32'hA5A5A5A5; rdv[1] = 32'hA5A5A5A5;
        a_req_in = 1'b1; a_addr_in = 32'h300;
        for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); if (a_gnt_out) seen = 1'b1; end
        a_req_in = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_out !== 1'b1) begin failures++; $display("FAIL midbusy_active: got mem_req %b expected 1", mem_req_out); end
        rst = 1'b1; #1;
        checks++; if ({a_gnt_out, a_done_out, a_err_out, b_gnt_out, b_done_out, b_err_out, mem_sel_out, mem_req_out, mem_we_out} !== 9'b0) begin failures++; $display("FAIL midbusy_ctrl: got %b expected 0", {a_gnt_out, a_done_out, a_err_out, b_gnt_out, b_done_out, b_err_out, mem_sel_out, mem_req_out, mem_we_out}); end
        checks++; if ({a_rdata_out, b_rdata_out, mem_addr_out, mem_wdata_out} !== 128'b0) begin failures++; $display("FAIL midbusy_data: got %h expected 0", {a_rdata_out, b_rdata_out, mem_addr_out, mem_wdata_out}); end
        @(negedge clk); rst = 1'b0; exp_last_b = 1'b1;
        #1 force_ack = 1'b1;
        @(negedge clk); #1 force_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (a_done_out || b_done_out) nd++; end
        checks++; if (nd !== 0 || a_rdata_out !== 32'h0) begin failures++; $display("FAIL late_ack: got dones %0d rdata %h expected 0 0", nd, a_rdata_out); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            bit          ra, rb, bwe;
            bit          e[2];
            logic [31:0] aa, ba, bw, ea, ew, ed;
            int          w, l, rc, pick;
            int          lat[2], g[2], d[2];
            logic        es, ewe;
            pick = $urandom_range(0, 2);
            ra = (pick != 1); rb = (pick != 0);
            aa = $urandom; ba = $urandom; bw = $urandom; bwe = $urandom;
            for (int k = 0; k < 2; k++) begin
                ack_at[k] = $urandom_range(0, 5); rdv[k] = $urandom;
                e[k] = !(ack_at[k] >= 1 && ack_at[k] <= TO);
                lat[k] = e[k] ? TO : ack_at[k];
            end
            w = (ra && rb) ? (exp_last_b ? 0 : 1) : (ra ? 0 : 1);
            l = 1 - w;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(ra, rb, aa, ba, bw, bwe, rc);
            g[w] = rc + 1; d[w] = g[w] + lat[w];
            g[l] = d[w] + 1; d[l] = g[l] + lat[l];
            exp_last_b = (ra && rb) ? (l == 1) : (w == 1);
            for (int k = 0; k < 2; k++) begin
                if (k == 0 ? ra : rb) begin
                    ea = (k == 0) ? aa : ba; ew = (k == 0) ? 32'h0 : bw; ewe = (k == 0) ? 1'b0 : bwe;
                    es = (k == 1); ed = e[k] ? 32'h0 : rdv[k];
                    checks++; if (gnt_c[k] !== g[k] || done_c[k] !== d[k] || ndone[k] !== 1) begin failures++; $display("FAIL rand%0d_timing[%0d]: got gnt %0d done %0d n %0d expected %0d %0d 1", it, k, gnt_c[k], done_c[k], ndone[k], g[k], d[k]); end
                    checks++; if (err_r[k] !== e[k] || rd_r[k] !== ed) begin failures++; $display("FAIL rand%0d_resp[%0d]: got err %b rdata %h expected %b %h", it, k, err_r[k], rd_r[k], e[k], ed); end
                    checks++; if (sel_r[k] !== es || we_r[k] !== ewe || addr_r[k] !== ea || wd_r[k] !== ew) begin failures++; $display("FAIL rand%0d_mem[%0d]: got %b %b %h %h expected %b %b %h %h", it, k, sel_r[k], we_r[k], addr_r[k], wd_r[k], es, ewe, ea, ew); end
                end else begin
                    checks++; if (ngnt[k] + ndone[k] !== 0) begin failures++; $display("FAIL rand%0d_idle[%0d]: got %0d pulses expected 0", it, k, ngnt[k] + ndone[k]); end
                end
            end
        end
    endtask

    initial begin
        ack_at[0] = 0; ack_at[1] = 0; rdv[0] = '0; rdv[1] = '0;
        test_reset();
        test_single_fetch();
        test_store();
        test_timeout();
        test_timeout_ack_edge();
        test_back_to_back();
        test_reset_midbusy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (requester A, read-only) and the load/store unit (requester B, read/write).
- Arbitrates between the two requesters with round-robin priority.
- Drives the select of the shared 2-1 address/data multiplexer and registers the winning request.
- Routes the memory response back to the winner, with a timeout for unresponsive memory.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port.
- DATA_WIDTH, 32, read/write data width.
- TIMEOUT_WIDTH, 8, width of the wait counter.
- TIMEOUT, 255, BUSY cycles without ack before the transaction errors out; must be between 1 and 2^TIMEOUT_WIDTH-1.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- a_req_in  input  1  fetch request; held until a_gnt_out.
- a_addr_in  input  ADDR_WIDTH  fetch address.
- a_gnt_out  output  1  one-cycle pulse: fetch request accepted.
- a_done_out  output  1  one-cycle pulse: fetch completed (or errored).
- a_err_out  output  1  pulse coincident with a_done_out on timeout.
- a_rdata_out  output  DATA_WIDTH  fetch read data; valid while a_done_out=1.
- b_req_in  input  1  load/store request; held until b_gnt_out.
- b_we_in  input  1  1=store, 0=load.
- b_addr_in  input  ADDR_WIDTH  load/store address.
- b_wdata_in  input  DATA_WIDTH  store data.
- b_gnt_out, b_done_out, b_err_out, b_rdata_out  outputs  1/1/1/DATA_WIDTH  as for A.
- mem_sel_out  output  1  shared multiplexer select; 0=A, 1=B.
- mem_req_out  output  1  memory request, high for the whole transaction.
- mem_we_out  output  1  write enable.
- mem_addr_out  output  ADDR_WIDTH  registered address.
- mem_wdata_out  output  DATA_WIDTH  registered write data.
- mem_rdata_in  input  DATA_WIDTH  memory read data; valid with mem_ack_in.
- mem_ack_in  input  1  memory completion, one cycle.

Behaviour:
- Reset (async, immediate on rst_in=1):
  - state=IDLE, last_grant=B (so A wins the first contention), wait counter=0.
  - All outputs 0, including rdata registers and mem_sel_out.
  - Any in-flight transaction is dropped; no done pulse is issued for it.
- States: IDLE, BUSY_A, BUSY_B.
- IDLE:
  - Only a_req_in high -> BUSY_A. Only b_req_in high -> BUSY_B.
  - Both high -> grant the requester that is not last_grant.
  - On the grant edge, register addr (and for B: we and wdata) into mem_addr_out/mem_we_out/mem_wdata_out. For A, mem_we_out=0 and mem_wdata_out=0.
  - On the grant edge, set mem_sel_out and last_grant, and clear the wait counter.
  - No request -> stay in IDLE; mem_* registers and mem_sel_out hold their last values.
- BUSY_x:
  - mem_req_out=1 (state decode).
  - x_gnt_out=1 in the first BUSY cycle only (registered pulse, 1 cycle after the request was seen in IDLE).
  - The requester may drop or change req/addr after the gnt cycle; the registered copies are used.
- mem_ack_in=1 in BUSY_x:
  - Capture mem_rdata_in into x_rdata_out.
  - Next cycle: x_done_out=1, state=IDLE, mem_req_out=0.
  - On a store, rdata captures whatever mem_rdata_in holds; the LSU ignores it.
- Timeout:
  - The counter increments every BUSY cycle without ack.
  - If the counter equals TIMEOUT-1 and there is no ack: next cycle x_done_out=1, x_err_out=1, x_rdata_out=0, state=IDLE.
  - Ack in the same cycle as the timeout condition: ack wins, no error.
- Throughput:
  - Request seen in IDLE at cycle N -> gnt at N+1 -> earliest done at N+2 if ack arrives at N+1.
  - The done cycle is an IDLE cycle, and a new arbitration happens in that same cycle. Back-to-back transactions therefore cost one IDLE cycle each.
- Ignored inputs:
  - mem_ack_in while in IDLE is ignored (no done pulse, no capture).
  - A requester's req while the other requester is being served is held pending; it is evaluated in the next IDLE cycle.
- done/err/gnt are one-cycle pulses, 0 otherwise. x_rdata_out holds its value until the next capture or timeout for that requester.

Test Plan:
- Reset then a_req_in=1, a_addr_in=0x100, ack 2 cycles after gnt with rdata=0xDEADBEEF:
  - a_gnt_out pulse 1 cycle after req.
  - mem_sel_out=0, mem_addr_out=0x100, mem_we_out=0.
  - a_done_out pulse with a_rdata_out=0xDEADBEEF; b_* outputs stay 0.
- b_req_in=1, b_we_in=1, addr=0x2000, wdata=0x12345678, immediate ack:
  - mem_sel_out=1, mem_we_out=1, mem_wdata_out=0x12345678.
  - b_done_out pulse with b_err_out=0.
- a_req_in and b_req_in both held high for 4 transactions, ack after 1 cycle each:
  - Grant order A, B, A, B.
  - Each done pulse goes only to the matching requester.
- TIMEOUT=4, B load with no ack:
  - After 4 BUSY cycles, b_done_out=1, b_err_out=1, b_rdata_out=0, state IDLE.
- Repeat the timeout case with ack arriving exactly in the 4th BUSY cycle -> normal done, err=0.
- rst_in asserted mid BUSY_A, then ack arrives after rst_in deasserts:
  - All outputs 0 immediately on reset.
  - No a_done_out pulse; the late ack is ignored in IDLE.
